// File: rtl/multiport_register_file.sv
// Parametrised register file: NUM_READ combinational read ports, two write ports
// (port 1 wins on collision), optional bypass and hardwired zero register.
module multiport_register_file_rdport #(
    parameter int WIDTH     = 64,
    parameter int ADDR_BITS = 5,
    parameter int ZERO_EN   = 1,
    parameter int ZERO_REG  = 31,
    parameter int BYPASS    = 1
) (
    input  logic                 Reset,
    input  logic [ADDR_BITS-1:0] rdAddr,
    input  logic [WIDTH-1:0]     storeData,
    input  logic [ADDR_BITS-1:0] RW0,
    input  logic [WIDTH-1:0]     BusW0,
    input  logic                 RegWr0,
    input  logic [ADDR_BITS-1:0] RW1,
    input  logic [WIDTH-1:0]     BusW1,
    input  logic                 RegWr1,
    output logic [WIDTH-1:0]     rdData
);
    localparam logic [ADDR_BITS-1:0] ZeroAddr = ADDR_BITS'(ZERO_REG);

    // Later assignments override earlier ones: port 1 beats port 0,
    // the zero register beats bypass, reset beats everything.
    always_comb begin
        rdData = storeData;
        if (BYPASS != 0 && RegWr0 && RW0 == rdAddr) rdData = BusW0;
        if (BYPASS != 0 && RegWr1 && RW1 == rdAddr) rdData = BusW1;
        if (ZERO_EN != 0 && rdAddr == ZeroAddr)     rdData = '0;
        if (Reset)                                  rdData = '0;
    end
endmodule

module multiport_register_file #(
    parameter int WIDTH     = 64,
    parameter int ADDR_BITS = 5,
    parameter int NUM_READ  = 2,
    parameter int ZERO_EN   = 1,
    parameter int ZERO_REG  = 31,
    parameter int BYPASS    = 1
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic [NUM_READ*ADDR_BITS-1:0] RA,
    output logic [NUM_READ*WIDTH-1:0]     BusA,
    input  logic [ADDR_BITS-1:0]          RW0,
    input  logic [WIDTH-1:0]              BusW0,
    input  logic                          RegWr0,
    input  logic [ADDR_BITS-1:0]          RW1,
    input  logic [WIDTH-1:0]              BusW1,
    input  logic                          RegWr1,
    output logic                          WrConflict
);
    localparam int                   Depth    = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] ZeroAddr = ADDR_BITS'(ZERO_REG);

    logic [WIDTH-1:0] regs [Depth];
    logic             wr0Ok;
    logic             wr1Ok;

    assign wr0Ok = RegWr0 && !(ZERO_EN != 0 && RW0 == ZeroAddr);
    assign wr1Ok = RegWr1 && !(ZERO_EN != 0 && RW1 == ZeroAddr);

    // Falling-edge commit lets a single-cycle datapath write late in the cycle.
    always_ff @(negedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < Depth; i++) regs[i] <= '0;
            WrConflict <= 1'b0;
        end else begin
            if (wr0Ok) regs[RW0] <= BusW0;
            if (wr1Ok) regs[RW1] <= BusW1;
            WrConflict <= RegWr0 && RegWr1 && (RW0 == RW1);
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [ADDR_BITS-1:0] rdAddr;
        assign rdAddr = RA[k*ADDR_BITS +: ADDR_BITS];

        multiport_register_file_rdport #(
            .WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS), .ZERO_EN(ZERO_EN),
            .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
        ) u_rd (
            .Reset    (Reset),
            .rdAddr   (rdAddr),
            .storeData(regs[rdAddr]),
            .RW0      (RW0),
            .BusW0    (BusW0),
            .RegWr0   (RegWr0),
            .RW1      (RW1),
            .BusW1    (BusW1),
            .RegWr1   (RegWr1),
            .rdData   (BusA[k*WIDTH +: WIDTH])
        );
    end
endmodule

// File: tb/tb_multiport_register_file.sv
// Bench for multiport_register_file: a bypassing and a non-bypassing instance
// share stimulus; expectations go through a queue scoreboard.
module tb_multiport_register_file;
    localparam int W  = 64;
    localparam int AB = 5;
    localparam int NR = 2;

    logic            Clk;
    logic            Reset;
    logic [NR*AB-1:0] RA;
    logic [NR*W-1:0]  busAB, busAN;
    logic [AB-1:0]   RW0, RW1;
    logic [W-1:0]    BusW0, BusW1;
    logic            RegWr0, RegWr1;
    logic            wcB, wcN;

    multiport_register_file #(.BYPASS(1)) dutB (
        .Clk(Clk), .Reset(Reset), .RA(RA), .BusA(busAB),
        .RW0(RW0), .BusW0(BusW0), .RegWr0(RegWr0),
        .RW1(RW1), .BusW1(BusW1), .RegWr1(RegWr1), .WrConflict(wcB));

    multiport_register_file #(.BYPASS(0)) dutN (
        .Clk(Clk), .Reset(Reset), .RA(RA), .BusA(busAN),
        .RW0(RW0), .BusW0(BusW0), .RegWr0(RegWr0),
        .RW1(RW1), .BusW1(BusW1), .RegWr1(RegWr1), .WrConflict(wcN));

    initial Clk = 1'b1;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    int nErrors = 0;
    int nChecks = 0;
    logic [W-1:0] sbq[$];

    task automatic want(input logic [W-1:0] v);
        sbq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [W-1:0] act);
        logic [W-1:0] e;
        nChecks++;
        if (sbq.size() == 0) begin
            nErrors++;
            $display("FAIL %s: got %h, no expected value queued", name, act);
            return;
        end
        e = sbq.pop_front();
        if (act !== e) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h", name, act, e);
        end
    endtask

    task automatic setRd(input int a0, input int a1);
        RA = {AB'(a1), AB'(a0)};
    endtask

    task automatic edgeWait();
        @(negedge Clk);
        #1;
    endtask

    typedef struct {
        int           ra0;
        int           ra1;
        logic [W-1:0] e0;
        logic [W-1:0] e1;
    } rdVec;

    rdVec tbl[16];

    initial begin
        for (int i = 0; i < 15; i++) begin
            tbl[i].ra0 = 2*i + 1;  tbl[i].e0 = W'(2*i + 1);
            tbl[i].ra1 = 2*i + 2;  tbl[i].e1 = W'(2*i + 2);
        end
        tbl[15].ra0 = 31; tbl[15].e0 = '0;
        tbl[15].ra1 = 0;  tbl[15].e1 = '0;

        Reset = 1'b1; RA = '0;
        RW0 = '0; BusW0 = '0; RegWr0 = 1'b0;
        RW1 = '0; BusW1 = '0; RegWr1 = 1'b0;
        edgeWait();
        Reset = 1'b0;

        // storage cleared by reset
        want(0); chk("rst_wc", W'(wcN));
        for (int k = 0; k < 32; k++) begin
            setRd(k, 31 - k); #1;
            want(0); chk($sformatf("rst_rd0_%0d", k), busAN[W-1:0]);
            want(0); chk($sformatf("rst_rd1_%0d", k), busAN[2*W-1:W]);
        end

        // reg k <= k via port 0
        for (int k = 0; k < 32; k++) begin
            RW0 = AB'(k); BusW0 = W'(k); RegWr0 = 1'b1;
            edgeWait();
        end
        RegWr0 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            setRd(tbl[i].ra0, tbl[i].ra1); #1;
            want(tbl[i].e0); chk($sformatf("tbl_n0_%0d", tbl[i].ra0), busAN[W-1:0]);
            want(tbl[i].e1); chk($sformatf("tbl_n1_%0d", tbl[i].ra1), busAN[2*W-1:W]);
            want(tbl[i].e0); chk($sformatf("tbl_b0_%0d", tbl[i].ra0), busAB[W-1:0]);
        end

        // bypass vs. no bypass
        setRd(5, 0); RW0 = 5; BusW0 = 64'h12345678; RegWr0 = 1'b1; #1;
        want(64'h12345678); chk("byp_pre_b", busAB[W-1:0]);
        want(64'd5);        chk("byp_pre_n", busAN[W-1:0]);
        edgeWait();
        RegWr0 = 1'b0; #1;
        want(64'h12345678); chk("byp_post_b", busAB[W-1:0]);
        want(64'h12345678); chk("byp_post_n", busAN[W-1:0]);

        // same-address collision: port 1 wins, flag for one cycle
        setRd(7, 7); RW0 = 7; BusW0 = 64'hAAAA; RW1 = 7; BusW1 = 64'hBBBB;
        RegWr0 = 1'b1; RegWr1 = 1'b1; #1;
        want(64'hBBBB); chk("col_byp_b", busAB[2*W-1:W]);
        edgeWait();
        RegWr0 = 1'b0; RegWr1 = 1'b0; #1;
        want(64'hBBBB); chk("col_reg7", busAN[W-1:0]);
        want(1);        chk("col_wc_set", W'(wcN));
        edgeWait();
        want(0);        chk("col_wc_clr", W'(wcB));

        // different addresses: both land, no flag
        setRd(7, 8); RW0 = 7; BusW0 = 64'hAAAA; RW1 = 8; BusW1 = 64'hBBBB;
        RegWr0 = 1'b1; RegWr1 = 1'b1;
        edgeWait();
        RegWr0 = 1'b0; RegWr1 = 1'b0; #1;
        want(64'hAAAA); chk("dual_reg7", busAN[W-1:0]);
        want(64'hBBBB); chk("dual_reg8", busAN[2*W-1:W]);
        want(0);        chk("dual_wc", W'(wcN));

        // collision on the zero register
        setRd(31, 31); RW0 = 31; RW1 = 31; BusW0 = 64'hFFFF; BusW1 = 64'hFFFF;
        RegWr0 = 1'b1; RegWr1 = 1'b1; #1;
        want(0); chk("zero_pre_b", busAB[W-1:0]);
        edgeWait();
        RegWr0 = 1'b0; RegWr1 = 1'b0; #1;
        want(0); chk("zero_post_b", busAB[W-1:0]);
        want(0); chk("zero_post_n", busAN[W-1:0]);
        want(1); chk("zero_wc", W'(wcB));

        // reset swallows a same-edge write
        setRd(3, 7); #1;
        want(64'd3); chk("rstw_before", busAN[W-1:0]);
        Reset = 1'b1; RW0 = 3; BusW0 = 64'h99; RegWr0 = 1'b1; #1;
        want(0); chk("rstw_pre_b", busAB[W-1:0]);
        want(0); chk("rstw_pre_n", busAN[W-1:0]);
        edgeWait();
        want(0); chk("rstw_during", busAB[W-1:0]);
        Reset = 1'b0; RegWr0 = 1'b0; #1;
        want(0); chk("rstw_reg3", busAN[W-1:0]);
        want(0); chk("rstw_reg7", busAN[2*W-1:W]);
        want(0); chk("rstw_wc", W'(wcN));
        RegWr0 = 1'b1;
        edgeWait();
        RegWr0 = 1'b0; #1;
        want(64'h99); chk("rstw_rewrite", busAN[W-1:0]);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end
endmodule
